// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: two-entry skid buffer with valid/ready handshake,
// flush with NOP bubble injection, and saturating stall/drop counters.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  NOP_VALUE = 'h13,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;
  logic [CNT_W-1:0]    drop_count_q, drop_count_d;
  logic                acc_in, acc_out;
  logic [1:0]          held;
  logic [1:0]          dropped;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Handshake outputs depend on the state register only, so in_ready is registered.
  assign out_valid   = (state_q != EMPTY);
  assign in_ready    = (state_q != TWO);
  assign out_data    = out_valid ? main_q : NOP_VALUE;
  assign stall_count = stall_count_q;
  assign drop_count  = drop_count_q;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    main_d        = main_q;
    skid_d        = skid_q;
    stall_count_d = stall_count_q;
    drop_count_d  = drop_count_q;
    held          = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
    // An entry leaving on acc_out in the flush cycle was delivered, not dropped.
    dropped       = held - {1'b0, acc_out} + {1'b0, acc_in};

    if (out_valid && !out_ready)
      stall_count_d = sat_add(stall_count_q, 2'd1);

    if (flush) begin
      state_d      = EMPTY;
      drop_count_d = sat_add(drop_count_q, dropped);
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_in) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_d = in_data;
          end else if (acc_in) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (acc_out) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (acc_out) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      stall_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Payload storage carries no reset; out_data is masked by state while empty.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule
